// File: rtl/apb_slave_pkg.sv
// ============================================================================
// Module      : apb_slave_pkg
// Description : Shared constants for the APB register slave: FSM encoding,
//               register offsets and the default ID value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_slave_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int unsigned REG_ID        = 0;
    localparam int unsigned REG_CNT       = 1;
    localparam int unsigned FIRST_SCRATCH = 2;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

endpackage

`default_nettype wire

// File: rtl/apb_regfile.sv
// ============================================================================
// Module      : apb_regfile
// Description : Register bank behind the APB slave: ID, transfer counter and
//               scratch registers, plus address/error decode of the setup phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] ID_VALUE  = DEFAULT_ID_VALUE,
    localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_addr,
    input  logic              i_write,
    output logic [REG_AW-1:0] o_offset,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_offset,
    input  logic [31:0]       i_wdata,
    input  logic              i_cnt_inc
);

    logic [31:0] r_cnt;
    logic [31:0] w_regs [NUM_REGS];
    logic        w_ro_target;

    assign o_offset    = i_addr[REG_AW+1:2];
    assign w_ro_target = (o_offset == REG_AW'(REG_ID)) || (o_offset == REG_AW'(REG_CNT));
    assign o_err       = (i_addr[31:REG_AW+2] != BASE_ADDR[31:REG_AW+2]) ||
                         (i_addr[1:0] != 2'b00) ||
                         (i_write && w_ro_target);

    // Slots below FIRST_SCRATCH are served by the read mux and carry no storage.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi < FIRST_SCRATCH) begin : g_fixed
            assign w_regs[gi] = '0;
        end else begin : g_scratch
            logic [31:0] r_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (i_wr_en && (i_wr_offset == REG_AW'(gi))) begin
                    r_q <= i_wdata;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_cnt_inc) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        o_rdata = w_regs[o_offset];
        if (o_offset == REG_AW'(REG_ID)) begin
            o_rdata = ID_VALUE;
        end else if (o_offset == REG_AW'(REG_CNT)) begin
            o_rdata = r_cnt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_reg_slave.sv
// ============================================================================
// Module      : apb_reg_slave
// Description : APB completer with programmable wait states and error
//               response, serving an apb_regfile bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int unsigned SLAVE_IDX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int unsigned c_REG_AW    = $clog2(NUM_REGS);
    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES);

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic [3:0]          r_wait;
    logic                r_write;
    logic                r_err;
    logic [c_REG_AW-1:0] r_offset;
    logic [c_REG_AW-1:0] w_offset;
    logic                w_err;
    logic [31:0]         w_rdata;
    logic                w_sel;
    logic                w_setup;
    logic                w_done;
    logic                w_abort;
    logic                w_unused;

    assign w_sel    = Pselx[SLAVE_IDX];
    assign w_unused = ^Pselx;

    // Pready comes purely from registered state so there is no input-to-output path.
    assign Pready  = (r_state == ST_ACCESS) && (r_wait == 4'd0);
    assign Pslverr = r_err && Pready;

    always_comb begin
        w_next_state = r_state;
        w_setup      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel && !Penable) begin
                    w_setup      = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!w_sel) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (Pready && Penable) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state  <= ST_IDLE;
            r_wait   <= 4'd0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_offset <= '0;
            Prdata   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_setup) begin
                r_write  <= Pwrite;
                r_offset <= w_offset;
                r_err    <= w_err;
                r_wait   <= c_WAIT_INIT;
                Prdata   <= (!Pwrite && !w_err) ? w_rdata : 32'd0;
            end else begin
                if ((r_state == ST_ACCESS) && (r_wait != 4'd0)) begin
                    r_wait <= r_wait - 4'd1;
                end
                if (w_done || w_abort) begin
                    Prdata <= '0;
                    r_err  <= 1'b0;
                end
            end
        end
    end

    apb_regfile #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .ID_VALUE  (ID_VALUE)
    ) u_regfile (
        .i_clk       (Hclk),
        .i_rst       (Hreset),
        .i_addr      (Paddr),
        .i_write     (Pwrite),
        .o_offset    (w_offset),
        .o_err       (w_err),
        .o_rdata     (w_rdata),
        .i_wr_en     (w_done && r_write && !r_err),
        .i_wr_offset (r_offset),
        .i_wdata     (Pwdata),
        .i_cnt_inc   (w_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
// ============================================================================
// Module      : tb_apb_reg_slave
// Description : Self-checking bench: two slaves (no wait / two waits) on one
//               bus, directed cases plus random traffic against a bank model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_reg_slave;

    localparam logic [31:0] C_BASE  = 32'h8000_0000;
    localparam logic [31:0] C_ID    = 32'hA5B0_0001;
    localparam int          C_NREGS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [2][C_NREGS];
    logic [31:0] m_cnt  [2];

    always #5 clk = ~clk;

    apb_reg_slave #(.SLAVE_IDX(0), .WAIT_STATES(0)) dut0 (
        .Hclk(clk), .Hreset(rst), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0)
    );

    apb_reg_slave #(.SLAVE_IDX(1), .WAIT_STATES(2)) dut1 (
        .Hclk(clk), .Hreset(rst), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int i);
        return (i == 0) ? prdata0 : prdata1;
    endfunction

    function automatic logic ready_of(input int i);
        return (i == 0) ? pready0 : pready1;
    endfunction

    function automatic logic slverr_of(input int i);
        return (i == 0) ? pslverr0 : pslverr1;
    endfunction

    function automatic int waits_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic wr);
        logic out_of_window;
        out_of_window = (addr < C_BASE) || (addr >= C_BASE + 32'(C_NREGS * 4));
        return out_of_window || (addr % 4 != 0) || (wr && ((addr - C_BASE) / 4 < 2));
    endfunction

    function automatic logic [31:0] model_read(input int idx, input int off);
        if (off == 0) return C_ID;
        if (off == 1) return m_cnt[idx];
        return m_regs[idx][off];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 32'd0;
            for (int r = 0; r < C_NREGS; r++) m_regs[d][r] = 32'd0;
        end
    endtask

    task automatic bus_idle();
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
    endtask

    // One complete transfer: setup, access with wait counting, then the idle cycle.
    task automatic xfer(input int idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
        logic        err;
        logic [31:0] exp_rd;
        int          off;
        int          waits;
        logic        done;
        off    = int'(addr[5:2]);
        err    = model_err(addr, wr);
        exp_rd = (!wr && !err) ? model_read(idx, off) : 32'd0;
        @(negedge clk);
        pselx   = 3'b001 << idx;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        done    = 1'b0;
        while (!done && waits < 20) begin
            if (ready_of(idx)) begin
                check({tag, "_waits"},     32'(waits),     32'(waits_of(idx)));
                check({tag, "_prdata"},    rdata_of(idx),  exp_rd);
                check({tag, "_pslverr"},   32'(slverr_of(idx)), 32'(err));
                check({tag, "_other_rdy"}, 32'(ready_of(1 - idx)), 32'd0);
                done = 1'b1;
            end else begin
                check({tag, "_early_err"}, 32'(slverr_of(idx)), 32'd0);
                waits++;
                @(negedge clk);
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (wr && !err) m_regs[idx][off] = data;
        m_cnt[idx] = m_cnt[idx] + 32'd1;
        @(negedge clk);
        check({tag, "_rd_clr"},  rdata_of(idx), 32'd0);
        check({tag, "_rdy_clr"}, 32'(ready_of(idx)), 32'd0);
        bus_idle();
    endtask

    initial begin
        logic [31:0] addr;
        int          idx;
        logic        wr;
        int          kind;

        bus_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_prdata",  prdata0,        32'd0);
        check("rst_pready",  32'(pready0),   32'd0);
        check("rst_pslverr", 32'(pslverr0),  32'd0);
        rst = 1'b0;

        xfer(0, 1'b0, C_BASE + 32'h4, 32'd0, "rst_cnt");
        xfer(0, 1'b0, C_BASE,         32'd0, "rst_id");

        xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, "wr8");
        xfer(0, 1'b0, 32'h8000_0008, 32'd0,         "rd8");
        xfer(0, 1'b0, 32'h8000_0004, 32'd0,         "cnt2");

        xfer(1, 1'b1, 32'h8000_000C, 32'h1234_5678, "ws_wr");
        xfer(1, 1'b0, 32'h8000_000C, 32'd0,         "ws_rd");

        xfer(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "err_wr_id");
        xfer(0, 1'b0, 32'h8000_0000, 32'd0,         "id_kept");
        xfer(0, 1'b0, 32'h8000_1000, 32'd0,         "err_window");
        xfer(0, 1'b0, 32'h8000_0009, 32'd0,         "err_misalign");
        xfer(1, 1'b1, 32'h8000_0004, 32'h0BAD_0BAD, "err_wr_cnt");

        // Access strobe with no setup must be ignored.
        @(negedge clk);
        pselx = 3'b001; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'h8000_0008; pwdata = 32'h1111_1111;
        repeat (2) begin
            @(negedge clk);
            check("nosetup_rdy", 32'(pready0), 32'd0);
        end
        bus_idle();

        // Select dropped mid-access on the waiting slave: no commit, no count.
        @(negedge clk);
        pselx = 3'b010; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h8000_0020; pwdata = 32'h7777_7777;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        pselx = 3'b000;
        @(negedge clk);
        check("drop_rdy", 32'(pready1), 32'd0);
        bus_idle();
        xfer(1, 1'b0, 32'h8000_0020, 32'd0, "drop_rd");
        xfer(1, 1'b0, 32'h8000_0004, 32'd0, "drop_cnt");

        // Slave 0 must be untouched by slave-1 traffic.
        xfer(0, 1'b0, 32'h8000_000C, 32'd0, "iso_rd");

        for (int n = 0; n < 80; n++) begin
            idx  = int'($urandom % 2);
            wr   = 1'($urandom % 2);
            kind = int'($urandom % 8);
            addr = C_BASE + 32'(4 * ($urandom % C_NREGS));
            if (kind == 6) addr = addr + 32'(1 + $urandom % 3);
            if (kind == 7) addr = C_BASE ^ (32'h1 << (6 + $urandom % 26));
            xfer(idx, wr, addr, $urandom, "rnd");
        end

        // Counter wrap: preload the count, then two reads of CNT.
        @(negedge clk);
        force dut0.u_regfile.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut0.u_regfile.r_cnt;
        m_cnt[0] = 32'hFFFF_FFFF;
        xfer(0, 1'b0, 32'h8000_0004, 32'd0, "wrap_pre");
        xfer(0, 1'b0, 32'h8000_0004, 32'd0, "wrap_post");

        // Reset in the access cycle of a write abandons it.
        @(negedge clk);
        pselx = 3'b001; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h8000_0010; pwdata = 32'h5555_5555;
        @(negedge clk);
        penable = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        model_reset();
        check("midrst_rdy", 32'(pready0), 32'd0);
        xfer(0, 1'b0, 32'h8000_0010, 32'd0, "midrst_rd");
        xfer(0, 1'b0, 32'h8000_0004, 32'd0, "midrst_cnt");
        xfer(1, 1'b0, 32'h8000_000C, 32'd0, "midrst_s1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
